// File: rtl/ram_arbiter_if.sv
// Bus bundle between two requesters (A: CPU, B: loader/debug), the arbiter
// and a synchronous single-port RAM.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until it sees gnt (a one-cycle pulse). It drops req in the cycle after gnt is
// visible; a req still high while gnt is visible is not a new request. Reads
// complete later with a one-cycle rvalid pulse; rdata holds until the next read
// on that port completes.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    // Requester / RAM side.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous single-port RAM.
// One access at a time: grant in IDLE, drive the RAM for one cycle in ACCESS,
// and for reads capture the registered RAM output in RDWAIT. All outputs are
// registered.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    ram_arbiter_if.slave bus,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_b_q, last_b_d;   // 1: port B was served last
    logic              sel_b_q, sel_b_d;     // port owning the in-flight access
    logic              op_we_q, op_we_d;     // in-flight access is a write
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              busy_q, busy_d;
    logic              grant_a, grant_b;

    // Next-state and next-output logic; holds everything not explicitly updated.
    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        sel_b_d     = sel_b_q;
        op_we_d     = op_we_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the port not served last wins.
                grant_a = bus.a_req && (!bus.b_req || last_b_q);
                grant_b = bus.b_req && (!bus.a_req || !last_b_q);
                if (grant_a) begin
                    state_d     = ACCESS;
                    last_b_d    = 1'b0;
                    sel_b_d     = 1'b0;
                    op_we_d     = bus.a_we;
                    mem_we_d    = bus.a_we;
                    mem_addr_d  = bus.a_addr;
                    mem_wdata_d = bus.a_wdata;
                    a_gnt_d     = 1'b1;
                end else if (grant_b) begin
                    state_d     = ACCESS;
                    last_b_d    = 1'b1;
                    sel_b_d     = 1'b1;
                    op_we_d     = bus.b_we;
                    mem_we_d    = bus.b_we;
                    mem_addr_d  = bus.b_addr;
                    mem_wdata_d = bus.b_wdata;
                    b_gnt_d     = 1'b1;
                end
            end
            ACCESS: begin
                state_d = op_we_q ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                state_d = IDLE;
                if (sel_b_q) begin
                    b_rdata_d  = bus.mem_rdata;
                    b_rvalid_d = 1'b1;
                end else begin
                    a_rdata_d  = bus.mem_rdata;
                    a_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            sel_b_q     <= 1'b0;
            op_we_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            sel_b_q     <= sel_b_d;
            op_we_q     <= op_we_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_gnt_q     <= a_gnt_d;
            b_gnt_q     <= b_gnt_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.a_gnt     = a_gnt_q;
    assign bus.b_gnt     = b_gnt_q;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then randomized two-port traffic,
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_ram_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         tests;
    int         fails;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model (registered read) ----------------
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input bit port, input bit we, input logic [7:0] addr,
                          input logic [7:0] wd, input bit hold);
        bit got;
        got = 1'b0;
        if (!port) begin
            bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; bus.a_req = 1'b1;
        end else begin
            bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd; bus.b_req = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            got = port ? bus.b_gnt : bus.a_gnt;
        end
        chk(port ? "b_gnt_seen" : "a_gnt_seen", {31'd0, got}, 32'd1);
        if (hold) begin
            @(posedge clk); #1;
        end
        if (!port) bus.a_req = 1'b0;
        else       bus.b_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_traffic(input bit port, input int n, input bit wr_only, input int max_gap);
        for (int k = 0; k < n; k++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 7));
            do_req(port, wr_only ? 1'b1 : 1'($urandom_range(0, 1)), a,
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Arbiter modelled as: one access at a time; a write occupies 2 cycles and
    // a read 3; ties go to the port not served last; read data is the model
    // memory content at grant time, due 2 cycles after the grant edge.
    logic [7:0]  model_mem [256];
    logic [24:0] exp_q [$];             // {due_cycle[15:0], port, data}
    int          cyc;
    bit          started;
    bit          s_rst, s_areq, s_breq, s_awe, s_bwe;
    logic [7:0]  s_aaddr, s_baddr, s_awd, s_bwd;
    int          free_at;
    bit          last_b;
    bit          e_ga, e_gb, e_rva, e_rvb, e_we, e_busy;
    logic [7:0]  e_addr, e_wd, e_ard, e_brd;

    // Sample what the DUT sees at each rising edge.
    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        s_rst   = rst;
        s_areq  = bus.a_req;  s_awe = bus.a_we;  s_aaddr = bus.a_addr;  s_awd = bus.a_wdata;
        s_breq  = bus.b_req;  s_bwe = bus.b_we;  s_baddr = bus.b_addr;  s_bwd = bus.b_wdata;
    end

    // Advance the model for the last edge and compare every output mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            logic [24:0] ent;
            logic [7:0]  g_addr, g_wd;
            bit          g_we;
            e_ga = 1'b0; e_gb = 1'b0; e_rva = 1'b0; e_rvb = 1'b0; e_we = 1'b0;
            if (s_rst) begin
                exp_q.delete();
                last_b  = 1'b1;
                free_at = cyc + 1;
                e_addr  = 8'h00; e_wd = 8'h00; e_ard = 8'h00; e_brd = 8'h00;
            end else begin
                if (exp_q.size() > 0 && exp_q[0][24:9] == 16'(cyc)) begin
                    ent = exp_q.pop_front();
                    if (ent[8]) begin e_rvb = 1'b1; e_brd = ent[7:0]; end
                    else        begin e_rva = 1'b1; e_ard = ent[7:0]; end
                end
                if (cyc >= free_at) begin
                    if (s_areq && s_breq) begin
                        e_ga = last_b;
                        e_gb = !last_b;
                    end else begin
                        e_ga = s_areq;
                        e_gb = s_breq;
                    end
                end
                if (e_ga || e_gb) begin
                    g_we   = e_gb ? s_bwe   : s_awe;
                    g_addr = e_gb ? s_baddr : s_aaddr;
                    g_wd   = e_gb ? s_bwd   : s_awd;
                    last_b = e_gb;
                    e_we   = g_we;
                    e_addr = g_addr;
                    e_wd   = g_wd;
                    if (g_we) begin
                        model_mem[g_addr] = g_wd;
                        free_at = cyc + 2;
                    end else begin
                        exp_q.push_back({16'(cyc + 2), e_gb, model_mem[g_addr]});
                        free_at = cyc + 3;
                    end
                end
            end
            e_busy = (cyc + 1 < free_at);
            chk("a_gnt",     {31'd0, bus.a_gnt},    {31'd0, e_ga});
            chk("b_gnt",     {31'd0, bus.b_gnt},    {31'd0, e_gb});
            chk("a_rvalid",  {31'd0, bus.a_rvalid}, {31'd0, e_rva});
            chk("b_rvalid",  {31'd0, bus.b_rvalid}, {31'd0, e_rvb});
            chk("a_rdata",   {24'd0, bus.a_rdata},  {24'd0, e_ard});
            chk("b_rdata",   {24'd0, bus.b_rdata},  {24'd0, e_brd});
            chk("mem_we",    {31'd0, bus.mem_we},   {31'd0, e_we});
            chk("mem_addr",  {24'd0, bus.mem_addr}, {24'd0, e_addr});
            chk("mem_wdata", {24'd0, bus.mem_wdata},{24'd0, e_wd});
            chk("busy",      {31'd0, bus.busy},     {31'd0, e_busy});
        end
    end

    // A write strobe never lasts more than one cycle.
    property p_we_pulse;
        @(posedge clk) disable iff (rst) bus.mem_we |=> !bus.mem_we;
    endproperty
    a_we_pulse: assert property (p_we_pulse)
        else begin
            fails++;
            $display("FAIL mem_we_pulse t=%0t got=two-cycle strobe exp=one-cycle", $time);
        end

    // ---------------- main sequence ----------------
    initial begin
        tests = 0; fails = 0; cyc = 0; started = 1'b0;
        free_at = 0; last_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'h00;
            model_mem[i] = 8'h00;
        end
        ram[255] = 8'hC3;
        model_mem[255] = 8'hC3;
        rst = 1'b1;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
        idle(3);
        rst = 1'b0;

        // B reads preloaded top address while A stays idle.
        do_req(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
        idle(4);
        chk("b_read_ff", {24'd0, bus.b_rdata}, 32'h0000_00C3);

        // A write 0x10 <- 0x5A then read back.
        do_req(1'b0, 1'b1, 8'h10, 8'h5A, 1'b0);
        do_req(1'b0, 1'b0, 8'h10, 8'h00, 1'b1);
        idle(4);
        chk("a_read_10", {24'd0, bus.a_rdata}, 32'h0000_005A);

        // Reset, then simultaneous reads: A must win the first tie.
        rst = 1'b1; idle(1); rst = 1'b0;
        fork
            do_req(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
            do_req(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
        join
        idle(5);

        // Reset while A's read sits in RDWAIT: no rvalid, outputs cleared.
        do_req(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_busy",   {31'd0, bus.busy},     32'd0);
        chk("rst_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
        chk("rst_rdata",  {24'd0, bus.a_rdata},  32'd0);
        idle(3);

        // Boundary data/address: 0x00 <- 0xFF, read back.
        do_req(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
        do_req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(4);
        chk("a_read_00", {24'd0, bus.a_rdata}, 32'h0000_00FF);

        // Back-to-back writes from both ports: grants must alternate.
        fork
            rand_traffic(1'b0, 10, 1'b1, 0);
            rand_traffic(1'b1, 10, 1'b1, 0);
        join
        idle(4);

        // Random mixed traffic.
        fork
            rand_traffic(1'b0, 60, 1'b0, 3);
            rand_traffic(1'b1, 60, 1'b0, 3);
        join
        idle(8);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
